// File: rtl/ps2_kbd_pkg.sv
// Shared constants, register map and receiver state encoding for the PS/2 keyboard block.
package ps2_kbd_pkg;

    localparam int   DATA_BUS     = 32;
    localparam logic MEM_READ     = 1'b1;

    localparam logic KBD_REG_DATA = 1'b0;
    localparam logic KBD_REG_STAT = 1'b1;

    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_PARITY    = 3;
    localparam int STAT_FRAME     = 4;
    localparam int STAT_CNT_LSB   = 8;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    // PS/2 uses odd parity over the data byte plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host deframer: pin synchronizers, falling-edge detect,
// 11-bit frame FSM with mid-frame timeout, parity and stop checks.
module ps2_rx_frame
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       parity_err_o,
    output logic       frame_err_o
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_prev_q;
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             byte_valid_q, byte_valid_d;
    logic [7:0]       byte_q, byte_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             fall_s;
    logic             bit_s;
    logic             timeout_s;

    assign fall_s    = clk_prev_q & ~clk_sync_q[1];
    assign bit_s     = data_sync_q[1];
    assign timeout_s = (state_q != RX_IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES));

    // Two-flop synchronizers plus previous-clock flop; idle line level is 1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    // Frame state and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
        end
    end

    // Next-state logic; result pulses default low.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        perr_d       = 1'b0;
        ferr_d       = 1'b0;

        if (fall_s || (state_q == RX_IDLE)) begin
            tmo_d = '0;
        end else if (timeout_s) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            RX_IDLE: begin
                if (fall_s && !bit_s) begin
                    state_d   = RX_SHIFT;
                    bit_cnt_d = 3'd0;
                end else begin
                    state_d   = RX_IDLE;
                end
            end
            RX_SHIFT: begin
                if (fall_s) begin
                    shift_d   = {bit_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        state_d = RX_SHIFT;
                    end
                end else if (timeout_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_SHIFT;
                end
            end
            RX_PARITY: begin
                if (fall_s) begin
                    par_d   = bit_s;
                    state_d = RX_STOP;
                end else if (timeout_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (fall_s) begin
                    state_d      = RX_IDLE;
                    perr_d       = ~odd_parity_ok(shift_q, par_q);
                    ferr_d       = ~bit_s;
                    byte_valid_d = bit_s & odd_parity_ok(shift_q, par_q);
                    byte_d       = shift_q;
                end else if (timeout_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_STOP;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_o       = byte_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/ps2_kbd.sv
// Memory-mapped PS/2 keyboard receiver: scancode FIFO, sticky error flags
// and the DATA/STATUS register interface on the CPU peripheral bus.
module ps2_kbd
    import ps2_kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ena_i,
    input  logic                rw_i,
    input  logic [DATA_BUS-1:0] addr_i,
    output logic [DATA_BUS-1:0] rdata_o,
    input  logic [DATA_BUS-1:0] wdata_i,
    input  logic                ps2_clk_i,
    input  logic                ps2_data_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]          mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic [DATA_BUS-1:0] rdata_q, rdata_d;

    logic                rx_valid_s;
    logic [7:0]          rx_byte_s;
    logic                rx_perr_s;
    logic                rx_ferr_s;
    logic                addr_ok_s;
    logic                rd_s;
    logic                stat_wr_s;
    logic                empty_s;
    logic                full_s;
    logic                pop_s;
    logic                push_s;
    logic [DATA_BUS-1:0] stat_s;
    logic                unused_s;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_valid_o (rx_valid_s),
        .byte_o       (rx_byte_s),
        .parity_err_o (rx_perr_s),
        .frame_err_o  (rx_ferr_s)
    );

    assign addr_ok_s = (addr_i[DATA_BUS-1:1] == '0);
    assign rd_s      = ena_i && (rw_i == MEM_READ) && addr_ok_s;
    assign stat_wr_s = ena_i && (rw_i != MEM_READ) && addr_ok_s && (addr_i[0] == KBD_REG_STAT);
    assign empty_s   = (count_q == '0);
    assign full_s    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop_s     = rd_s && (addr_i[0] == KBD_REG_DATA) && !empty_s;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign push_s    = rx_valid_s && (!full_s || pop_s);
    assign unused_s  = ^{wdata_i[DATA_BUS-1:5], wdata_i[1:0]};

    // STATUS register image.
    always_comb begin
        stat_s                = '0;
        stat_s[STAT_NONEMPTY] = ~empty_s;
        stat_s[STAT_FULL]     = full_s;
        stat_s[STAT_OVERFLOW] = ovf_q;
        stat_s[STAT_PARITY]   = perr_q;
        stat_s[STAT_FRAME]    = ferr_q;
        stat_s[STAT_CNT_LSB +: 4] = 4'(count_q);
    end

    // FIFO pointers/count, sticky flags and read data next state.
    always_comb begin
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clears are applied first so a same-cycle set event wins.
        ovf_d  = (stat_wr_s && wdata_i[STAT_OVERFLOW]) ? 1'b0 : ovf_q;
        perr_d = (stat_wr_s && wdata_i[STAT_PARITY])   ? 1'b0 : perr_q;
        ferr_d = (stat_wr_s && wdata_i[STAT_FRAME])    ? 1'b0 : ferr_q;
        if (rx_valid_s && !push_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_d;
        end
        if (rx_perr_s) begin
            perr_d = 1'b1;
        end else begin
            perr_d = perr_d;
        end
        if (rx_ferr_s) begin
            ferr_d = 1'b1;
        end else begin
            ferr_d = ferr_d;
        end

        if (!(ena_i && (rw_i == MEM_READ))) begin
            rdata_d = rdata_q;
        end else if (!addr_ok_s) begin
            rdata_d = '0;
        end else if (addr_i[0] == KBD_REG_STAT) begin
            rdata_d = stat_s;
        end else if (!empty_s) begin
            rdata_d = {{(DATA_BUS-8){1'b0}}, mem_q[rd_ptr_q]};
        end else begin
            rdata_d = '0;
        end
    end

    // Control and bus registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            rdata_q  <= rdata_d;
        end
    end

    // FIFO storage; contents are don't-care while count is zero.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= rx_byte_s;
        end
    end

    assign rdata_o = rdata_q;

endmodule
